rule110_seq_ctrl: RTL
=====================

// Module: rule110_seq_ctrl
// PURPOSE
//   Command-driven sequencer for a Rule 110 cellular-automaton row.
//   Loads a seed byte-wise, steps N generations, and streams the row out bytewise under valid/ready.
//   Sits between the tt_um_rule110_an top-level pin mapping and the cell row, which it owns.
//   Single clock domain.
// PARAMETERS
//   CELLS  32  row width in cells; multiple of 8, >= 8
//   GEN_W  16  width of the generation counter
// PORTS
//   clk        in   1       clock
//   rst_n      in   1       reset, asynchronous, active-low
//   ena        in   1       design enable; low = freeze (no state change)
//   cmd_valid  in   1       command present
//   cmd_op     in   2       00 CLEAR, 01 LOAD, 10 RUN, 11 READ
//   cmd_arg    in   8       LOAD: seed byte; RUN: generation count N; else ignored
//   cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//   rd_valid   out  1       read byte available
//   rd_data    out  8       read byte
//   rd_ready   in   1       consumer accepts rd_data
//   busy       out  1       high in RUN or READ
//   done       out  1       1-cycle pulse after last RUN step or last READ beat
//   row_o      out  CELLS   current row, bit i = cell i
//   gen_count  out  GEN_W   generations stepped since CLEAR, wraps mod 2^GEN_W
// BEHAVIOUR
//   Reset (async, rst_n=0): row=0, load_ptr=0, gen_count=0, state IDLE.
//     All outputs 0 while in reset, including cmd_ready.
//   States: IDLE, RUN, READ. cmd_ready = ena & (state==IDLE). Commands are accepted only in IDLE.
//   CLEAR: row=0, load_ptr=0, gen_count=0. Takes one cycle; state stays IDLE.
//   LOAD: row byte[load_ptr] <= cmd_arg; load_ptr++ wraps BYTES-1 -> 0 (BYTES=CELLS/8).
//     One cycle; state stays IDLE. gen_count is unchanged.
//   RUN N:
//     - N=0: no-op. No step, no busy, no done.
//     - N>0: go to RUN. Exactly one generation per enabled cycle, N cycles total.
//     - gen_count += 1 per step.
//     - done pulses the cycle after the last step; back to IDLE that same cycle.
//   Rule 110 per cell i: l=cell[i+1], c=cell[i], r=cell[i-1].
//     Cells outside the row read as 0 (null boundary).
//     next = (c ^ r) | (c & ~l). All cells update simultaneously.
//   READ:
//     - Go to READ with beat index 0; rd_valid=1; rd_data = byte[idx], byte 0 = cells 7:0 first.
//     - A beat completes on rd_valid & rd_ready & ena; idx++.
//     - rd_data is stable while rd_valid & ~rd_ready.
//     - After beat BYTES-1 completes: done pulses, IDLE. Row is unchanged by READ.
//   ena=0: no state, row, counter or pointer change; cmd_ready=0; rd_valid=0.
//     RUN and READ resume exactly where they paused.
//   rd_ready outside READ is ignored. cmd_valid while busy is not accepted (cmd_ready=0).
//   Reset mid-RUN or mid-READ aborts immediately; outputs return to reset values.
// STRUCTURE
//   Package rule110_pkg: cmd_op encodings (OP_CLEAR/LOAD/RUN/READ), state enum,
//     function rule110_next(l,c,r).
//   Sub-module rule110_row holds the CELLS-bit register and next-state logic.
//     Inputs: clear, step, load_en, load_idx, load_byte. Output: row.
//   rule110_seq_ctrl holds the FSM, load_ptr, run counter (8 b), read index, gen_count.
// TESTING (CELLS=32)
//   1. Reset: rst_n=0 -> all outputs 0.
//      Release, ena=1 -> cmd_ready=1, row_o=0, gen_count=0.
//   2. CLEAR, LOAD 01,00,00,00 -> row_o=0x00000001.
//      RUN 1 -> 0x00000003. Then RUN 2 -> 0x0000000D with busy exactly 2 cycles,
//      done 1 cycle, gen_count=3.
//   3. LOAD FF x4 -> 0xFFFFFFFF. RUN 1 -> 0x80000001.
//      Then LOAD AA x4 + 5th LOAD 55 -> byte0=0x55 (pointer wrap).
//   4. Row 0x44332211, READ with rd_ready toggling 1/0 -> bytes 11,22,33,44.
//      rd_data stable while stalled. Exactly 4 beats, then done, then cmd_ready=1.
//   5. RUN 8 with ena low for 3 cycles mid-run -> exactly 8 steps.
//      busy spans 11 cycles; result equals uninterrupted RUN 8.
//   6. RUN 0 -> no busy/done, row unchanged.
//      Assert rst_n=0 mid-READ -> rd_valid=0 immediately, row_o=0.

Source files
------------

// File: rtl/rule110_pkg.sv
// Shared encodings and the Rule 110 cell function for the sequencer slice.
package rule110_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_READ = 2'd2
  } state_t;

  // Rule 110: a cell survives unless all three are set, and is born from a live right neighbour.
  function automatic logic rule110_next(input logic l, input logic c, input logic r);
    return (c ^ r) | (c & ~l);
  endfunction

endpackage

// File: rtl/rule110_row.sv
// Cell row register: byte-wise load, synchronous clear and one-generation step.
module rule110_row
  import rule110_pkg::*;
#(
  parameter int CELLS = 32,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic             i_load_en,
  input  logic [IDX_W-1:0] i_load_idx,
  input  logic [7:0]       i_load_byte,
  output logic [CELLS-1:0] o_row
);

  localparam int BYTES = CELLS / 8;

  logic [BYTES-1:0][7:0] r_row;
  logic [CELLS+1:0]      w_ext;
  logic [CELLS-1:0]      w_next;

  // Zero pad on both ends gives the null boundary for cells 0 and CELLS-1.
  assign w_ext = {1'b0, r_row, 1'b0};

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign w_next[i] = rule110_next(w_ext[i+2], w_ext[i+1], w_ext[i]);
  end

  // Row state: clear wins over load, load over step (they are never issued together).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (i_clear) begin
      r_row <= '0;
    end else if (i_load_en) begin
      r_row[i_load_idx] <= i_load_byte;
    end else if (i_step) begin
      r_row <= w_next;
    end
  end

  assign o_row = r_row;

endmodule

// File: rtl/rule110_seq_ctrl.sv
// Command sequencer: CLEAR / LOAD / RUN N / READ over a Rule 110 row.
module rule110_seq_ctrl
  import rule110_pkg::*;
#(
  parameter int CELLS = 32,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  output logic             cmd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] row_o,
  output logic [GEN_W-1:0] gen_count
);

  localparam int BYTES = CELLS / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_load_ptr;
  logic [IDX_W-1:0] r_rd_idx;
  logic [7:0]       r_run_cnt;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_done;

  logic             w_accept, w_clear, w_load, w_run, w_read;
  logic             w_step, w_beat, w_last_step, w_last_beat;
  logic [CELLS-1:0] w_row;
  logic [BYTES-1:0][7:0] w_bytes;

  // Reset is folded into cmd_ready so nothing looks acceptable while held in reset.
  assign cmd_ready = rst_n & ena & (r_state == ST_IDLE);
  assign rd_valid  = ena & (r_state == ST_READ);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign row_o     = w_row;
  assign gen_count = r_gen_count;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_clear     = w_accept & (cmd_op == OP_CLEAR);
  assign w_load      = w_accept & (cmd_op == OP_LOAD);
  assign w_run       = w_accept & (cmd_op == OP_RUN) & (cmd_arg != 8'd0);
  assign w_read      = w_accept & (cmd_op == OP_READ);
  assign w_step      = ena & (r_state == ST_RUN);
  assign w_beat      = rd_valid & rd_ready;
  assign w_last_step = w_step & (r_run_cnt == 8'd1);
  assign w_last_beat = w_beat & (r_rd_idx == LAST_IDX);

  assign w_bytes = w_row;
  assign rd_data = rd_valid ? w_bytes[r_rd_idx] : 8'h00;

  // Next-state: RUN N=0 is swallowed in IDLE, busy states exit on their final step/beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run)       w_state_nxt = ST_RUN;
        else if (w_read) w_state_nxt = ST_READ;
      end
      ST_RUN:  if (w_last_step) w_state_nxt = ST_IDLE;
      ST_READ: if (w_last_beat) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pointers and counters; every update is qualified by ena through accept/step/beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_ptr  <= '0;
      r_rd_idx    <= '0;
      r_run_cnt   <= '0;
      r_gen_count <= '0;
    end else begin
      if (w_clear) begin
        r_load_ptr  <= '0;
        r_gen_count <= '0;
      end
      if (w_load)
        r_load_ptr <= (r_load_ptr == LAST_IDX) ? '0 : r_load_ptr + IDX_W'(1);
      if (w_run)
        r_run_cnt <= cmd_arg;
      if (w_step) begin
        r_run_cnt   <= r_run_cnt - 8'd1;
        r_gen_count <= r_gen_count + GEN_W'(1);
      end
      if (w_read)
        r_rd_idx <= '0;
      else if (w_beat)
        r_rd_idx <= r_rd_idx + IDX_W'(1);
    end
  end

  // done is a single-cycle pulse in the first IDLE cycle after a RUN or READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_last_step | w_last_beat;
  end

  rule110_row #(
    .CELLS (CELLS),
    .IDX_W (IDX_W)
  ) u_row (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_step      (w_step),
    .i_load_en   (w_load),
    .i_load_idx  (r_load_ptr),
    .i_load_byte (cmd_arg),
    .o_row       (w_row)
  );

endmodule
